// File: rtl/chicken_turn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// chicken_pkg
// Shared constants and types for the Chicken Cha-Cha-Cha turn scheduler:
// ring length, field widths, start positions per player count, FSM states.
// No ports (package).
// ---------------------------------------------------------------------------
package chicken_pkg;

    localparam int TILES       = 24;
    localparam int POS_W       = 5;
    localparam int TAIL_W      = 3;
    localparam int PIDX_W      = 2;
    localparam int N_W         = 3;
    localparam int MAX_PLAYERS = 4;

    // Start tiles per player count; unused slots sit on tile 0.
    localparam logic [POS_W-1:0] START_N2 [MAX_PLAYERS] = '{5'd0, 5'd12, 5'd0,  5'd0};
    localparam logic [POS_W-1:0] START_N3 [MAX_PLAYERS] = '{5'd0, 5'd8,  5'd16, 5'd0};
    localparam logic [POS_W-1:0] START_N4 [MAX_PLAYERS] = '{5'd0, 5'd6,  5'd12, 5'd18};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        WAIT_FLIP = 3'd2,
        MOVE      = 3'd3,
        CHECK     = 3'd4,
        NEXT      = 3'd5,
        WIN       = 3'd6
    } state_t;

    // Start tile of player slot idx for a game of n players.
    function automatic logic [POS_W-1:0] start_pos(input logic [N_W-1:0] n,
                                                   input logic [PIDX_W-1:0] idx);
        logic [POS_W-1:0] v;
        v = '0;
        case (n)
            3'd2:    v = START_N2[idx];
            3'd3:    v = START_N3[idx];
            3'd4:    v = START_N4[idx];
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/chicken_turn_ctrl_if.sv
// ---------------------------------------------------------------------------
// chicken_turn_ctrl_if
// Bundles the game-control, flip handshake and status signals of the turn
// scheduler.
//   master : card-flip / host side (drives start, n_players, flip_*)
//   slave  : chicken_turn_ctrl (drives flip_ready and all status outputs)
//
// Flip handshake: a flip transfers on a rising clock edge where both
// flip_valid and flip_ready are high; flip_match is qualified by flip_valid.
// A flip presented while flip_ready is low is dropped, never queued, and
// the master need not hold flip_valid until ready.
// ---------------------------------------------------------------------------
interface chicken_turn_ctrl_if;
    import chicken_pkg::*;

    logic        start;
    logic [3:0]  n_players;
    logic        flip_valid;
    logic        flip_match;
    logic        flip_ready;
    logic [1:0]  cur_player;
    logic [19:0] pos_flat;
    logic [11:0] tails_flat;
    logic        move_pulse;
    logic        catch_pulse;
    logic        game_active;
    logic        winner_valid;
    logic [1:0]  winner;
    state_t      dbg_state;

    modport master (
        output start, n_players, flip_valid, flip_match,
        input  flip_ready, cur_player, pos_flat, tails_flat, move_pulse,
               catch_pulse, game_active, winner_valid, winner, dbg_state
    );

    modport slave (
        input  start, n_players, flip_valid, flip_match,
        output flip_ready, cur_player, pos_flat, tails_flat, move_pulse,
               catch_pulse, game_active, winner_valid, winner, dbg_state
    );

endinterface

// File: rtl/chicken_turn_ctrl_player_pos_ctr.sv
// ---------------------------------------------------------------------------
// player_pos_ctr
// Position of one player on the ring: mod-TILES counter with synchronous
// load of the start tile and an increment enable. Load wins over increment.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (position -> 0)
//   i_load     : load i_load_val on the next edge
//   i_load_val : start tile
//   i_inc      : advance one tile (TILES-1 wraps to 0)
//   o_pos      : current tile
// ---------------------------------------------------------------------------
module player_pos_ctr
    import chicken_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [POS_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic [POS_W-1:0] o_pos
);

    logic [POS_W-1:0] r_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= '0;
        end else if (i_load) begin
            r_pos <= i_load_val;
        end else if (i_inc) begin
            r_pos <= (r_pos == POS_W'(TILES - 1)) ? '0 : r_pos + POS_W'(1);
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/chicken_turn_ctrl.sv
// ---------------------------------------------------------------------------
// chicken_turn_ctrl
// Turn scheduler for the Chicken Cha-Cha-Cha board: loads start positions
// for 2-4 players, grants flips to one player at a time, moves the active
// player on a matching flip, transfers a tail when it lands on another
// player, and declares the winner once one player holds all N tails.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset; every output returns to 0
//   bus  : chicken_turn_ctrl_if.slave (start/n_players, flip handshake,
//          cur_player, pos_flat, tails_flat, pulses, game/winner status,
//          dbg_state)
// Build option: define CHICKEN_TURN_TIMEOUT_EN to end a turn after
// TIMEOUT_CYC cycles in WAIT_FLIP without a flip (treated as a mismatch).
// ---------------------------------------------------------------------------
module chicken_turn_ctrl
    import chicken_pkg::*;
`ifdef CHICKEN_TURN_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 1000
)
`endif
(
    input logic               clk,
    input logic               rst,
    chicken_turn_ctrl_if.slave bus
);

    state_t              r_state;
    logic [N_W-1:0]      r_n;
    logic [PIDX_W-1:0]   r_cur;
    logic [TAIL_W-1:0]   r_tails [MAX_PLAYERS];

    logic                r_flip_ready;
    logic                r_move_pulse;
    logic                r_catch_pulse;
    logic                r_game_active;
    logic                r_winner_valid;
    logic [PIDX_W-1:0]   r_cur_out;
    logic [PIDX_W-1:0]   r_winner;

    logic [POS_W-1:0]    w_pos [MAX_PLAYERS];
    logic [MAX_PLAYERS-1:0] w_inc;
    logic                w_load;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_timeout;
    logic                w_hit;
    logic [PIDX_W-1:0]   w_victim;
    logic [TAIL_W-1:0]   w_cur_tails_new;

    assign w_start_ok = bus.start && (bus.n_players inside {4'd2, 4'd3, 4'd4});
    assign w_accept   = (r_state == WAIT_FLIP) && r_flip_ready && bus.flip_valid;
    assign w_load     = (r_state == INIT);

    // ---------------- position counters ----------------
    for (genvar gi = 0; gi < MAX_PLAYERS; gi++) begin : g_pos
        assign w_inc[gi] = (r_state == MOVE) && (r_cur == PIDX_W'(gi));

        player_pos_ctr u_ctr (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load),
            .i_load_val (start_pos(r_n, PIDX_W'(gi))),
            .i_inc      (w_inc[gi]),
            .o_pos      (w_pos[gi])
        );
    end

    // ---------------- turn timeout ----------------
`ifdef CHICKEN_TURN_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Held at 0 outside WAIT_FLIP, so every entry into WAIT_FLIP starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != WAIT_FLIP) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // An accepted flip in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state == WAIT_FLIP) && !w_accept &&
                       (r_to_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ---------------- catch detection ----------------
    // Lowest-index other active player sharing the mover's tile that still
    // has a tail to give. Evaluated in CHECK, after the move has landed.
    always_comb begin
        w_hit    = 1'b0;
        w_victim = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if ((N_W'(i) < r_n) && (PIDX_W'(i) != r_cur) &&
                (w_pos[i] == w_pos[r_cur]) && (r_tails[i] != '0)) begin
                w_hit    = 1'b1;
                w_victim = PIDX_W'(i);
            end
        end
    end

    assign w_cur_tails_new = r_tails[r_cur] + TAIL_W'(w_hit);

    // ---------------- FSM, tails and registered outputs ----------------
    // Status outputs (flip_ready, cur_player, game_active, winner*) are
    // registered copies of the state one edge later; flip_ready also drops
    // on the accepting edge so it is never high outside an open flip window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_n            <= '0;
            r_cur          <= '0;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                r_tails[i] <= '0;
            end
            r_flip_ready   <= 1'b0;
            r_move_pulse   <= 1'b0;
            r_catch_pulse  <= 1'b0;
            r_game_active  <= 1'b0;
            r_winner_valid <= 1'b0;
            r_cur_out      <= '0;
            r_winner       <= '0;
        end else begin
            r_flip_ready   <= (r_state == WAIT_FLIP) && !w_accept && !w_timeout;
            r_move_pulse   <= (r_state == MOVE);
            r_catch_pulse  <= 1'b0;
            r_game_active  <= (r_state != IDLE) && (r_state != WIN);
            r_winner_valid <= (r_state == WIN);
            r_cur_out      <= r_cur;
            if (r_state == WIN) begin
                r_winner <= r_cur;
            end

            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_n     <= bus.n_players[N_W-1:0];
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_cur <= '0;
                    for (int i = 0; i < MAX_PLAYERS; i++) begin
                        r_tails[i] <= (N_W'(i) < r_n) ? TAIL_W'(1) : '0;
                    end
                    r_state <= WAIT_FLIP;
                end
                WAIT_FLIP: begin
                    if (w_accept) begin
                        r_state <= bus.flip_match ? MOVE : NEXT;
                    end else if (w_timeout) begin
                        r_state <= NEXT;
                    end
                end
                MOVE: begin
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_hit) begin
                        r_tails[w_victim] <= r_tails[w_victim] - TAIL_W'(1);
                        r_tails[r_cur]    <= w_cur_tails_new;
                        r_catch_pulse     <= 1'b1;
                    end
                    r_state <= (w_cur_tails_new == r_n) ? WIN : WAIT_FLIP;
                end
                NEXT: begin
                    r_cur   <= (r_cur == PIDX_W'(r_n - N_W'(1))) ? '0 : r_cur + PIDX_W'(1);
                    r_state <= WAIT_FLIP;
                end
                WIN: begin
                    if (w_start_ok) begin
                        r_n     <= bus.n_players[N_W-1:0];
                        r_state <= INIT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ---------------- output mapping ----------------
    assign bus.flip_ready   = r_flip_ready;
    assign bus.cur_player   = r_cur_out;
    assign bus.pos_flat     = {w_pos[3], w_pos[2], w_pos[1], w_pos[0]};
    assign bus.tails_flat   = {r_tails[3], r_tails[2], r_tails[1], r_tails[0]};
    assign bus.move_pulse   = r_move_pulse;
    assign bus.catch_pulse  = r_catch_pulse;
    assign bus.game_active  = r_game_active;
    assign bus.winner_valid = r_winner_valid;
    assign bus.winner       = r_winner;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_chicken_turn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chicken_turn_ctrl
// Self-checking bench for chicken_turn_ctrl. A game-level model (tile ring,
// tail counts, whose turn) predicts every observable output; scenario tasks
// drive flips and compare inline. Inputs and samples happen on the falling
// edge. With CHICKEN_TURN_TIMEOUT_EN the DUT is built with TIMEOUT_CYC=10.
// ---------------------------------------------------------------------------
module tb_chicken_turn_ctrl;
    import chicken_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // game-level reference model
    int   m_n;
    int   m_cur;
    int   m_pos   [4];
    int   m_tails [4];
    bit   m_won;

    chicken_turn_ctrl_if bus();

`ifdef CHICKEN_TURN_TIMEOUT_EN
    chicken_turn_ctrl #(.TIMEOUT_CYC(10)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    chicken_turn_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_clear();
        m_n = 0; m_cur = 0; m_won = 0;
        for (int i = 0; i < 4; i++) begin
            m_pos[i] = 0; m_tails[i] = 0;
        end
    endtask

    // Players are spread evenly round the ring.
    task automatic model_start(input int n);
        model_clear();
        m_n = n;
        for (int i = 0; i < n; i++) begin
            m_pos[i]   = i * TILES / n;
            m_tails[i] = 1;
        end
    endtask

    function automatic bit model_match();
        bit caught = 0;
        m_pos[m_cur] = (m_pos[m_cur] + 1) % TILES;
        for (int j = 0; j < m_n; j++) begin
            if (!caught && j != m_cur && m_pos[j] == m_pos[m_cur] && m_tails[j] > 0) begin
                m_tails[j]--;
                m_tails[m_cur]++;
                caught = 1;
            end
        end
        if (m_tails[m_cur] == m_n) m_won = 1;
        return caught;
    endfunction

    function automatic logic [19:0] exp_pos_flat();
        logic [19:0] v = '0;
        for (int i = 0; i < 4; i++) v[5*i +: 5] = 5'(m_pos[i]);
        return v;
    endfunction

    function automatic logic [11:0] exp_tails_flat();
        logic [11:0] v = '0;
        for (int i = 0; i < 4; i++) v[3*i +: 3] = 3'(m_tails[i]);
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0; bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic start_game(input int n, input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_players = 4'(n);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        checks++;
        if (bus.flip_ready !== 1'b0) begin
            errors++; $display("FAIL start_ready_early: got %b want 0", bus.flip_ready);
        end
        @(negedge clk);
        model_start(n);
        checks++;
        if (bus.pos_flat !== exp_pos_flat()) begin
            errors++; $display("FAIL start_pos n=%0d: got %h want %h", n, bus.pos_flat, exp_pos_flat());
        end
        checks++;
        if (bus.tails_flat !== exp_tails_flat()) begin
            errors++; $display("FAIL start_tails n=%0d: got %h want %h", n, bus.tails_flat, exp_tails_flat());
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.flip_ready !== 1'b1 || bus.cur_player !== 2'd0 || bus.game_active !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: ready=%b cur=%0d active=%b want 1/0/1",
                     bus.flip_ready, bus.cur_player, bus.game_active);
        end
    endtask

    // Present a flip at the current falling edge and follow it to completion.
    task automatic do_flip_now(input bit m);
        bit caught = 0;
        bus.flip_valid = 1'b1;
        bus.flip_match = m;
        @(negedge clk);
        bus.flip_valid = 1'b0;
        bus.flip_match = 1'b0;
        checks++;
        if (bus.flip_ready !== 1'b0) begin
            errors++; $display("FAIL flip_ready_drop: got %b want 0", bus.flip_ready);
        end
        if (m) begin
            caught = model_match();
            @(negedge clk);
            checks++;
            if (bus.pos_flat !== exp_pos_flat() || bus.move_pulse !== 1'b1) begin
                errors++;
                $display("FAIL move: pos=%h pulse=%b want pos=%h pulse=1",
                         bus.pos_flat, bus.move_pulse, exp_pos_flat());
            end
            @(negedge clk);
            checks++;
            if (bus.tails_flat !== exp_tails_flat() || bus.catch_pulse !== caught ||
                bus.move_pulse !== 1'b0) begin
                errors++;
                $display("FAIL check: tails=%h catch=%b move=%b want tails=%h catch=%b move=0",
                         bus.tails_flat, bus.catch_pulse, bus.move_pulse, exp_tails_flat(), caught);
            end
            @(negedge clk);
            checks++;
            if (m_won) begin
                if (bus.winner_valid !== 1'b1 || bus.winner !== 2'(m_cur) ||
                    bus.flip_ready !== 1'b0 || bus.game_active !== 1'b0) begin
                    errors++;
                    $display("FAIL win: valid=%b winner=%0d ready=%b active=%b want 1/%0d/0/0",
                             bus.winner_valid, bus.winner, bus.flip_ready, bus.game_active, m_cur);
                end
            end else begin
                if (bus.flip_ready !== 1'b1 || bus.cur_player !== 2'(m_cur) ||
                    bus.winner_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL after_move: ready=%b cur=%0d wv=%b want 1/%0d/0",
                             bus.flip_ready, bus.cur_player, bus.winner_valid, m_cur);
                end
            end
        end else begin
            m_cur = (m_cur + 1) % m_n;
            @(negedge clk);
            checks++;
            if (bus.flip_ready !== 1'b0) begin
                errors++; $display("FAIL next_ready_early: got %b want 0", bus.flip_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.cur_player !== 2'(m_cur) || bus.flip_ready !== 1'b1) begin
                errors++;
                $display("FAIL next: cur=%0d ready=%b want %0d/1", bus.cur_player, bus.flip_ready, m_cur);
            end
        end
    endtask

    task automatic do_flip(input bit m);
        int w = 0;
        while (bus.flip_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.flip_ready !== 1'b1) begin
            errors++; $display("FAIL ready_timeout: flip_ready=%b after %0d cycles", bus.flip_ready, w);
        end else begin
            do_flip_now(m);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.n_players = 4'd0; bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.pos_flat !== 20'd0 || bus.tails_flat !== 12'd0 || bus.cur_player !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: pos=%h tails=%h cur=%0d want 0", bus.pos_flat, bus.tails_flat, bus.cur_player);
        end
        checks++;
        if (bus.flip_ready !== 1'b0 || bus.move_pulse !== 1'b0 || bus.catch_pulse !== 1'b0 ||
            bus.game_active !== 1'b0 || bus.winner_valid !== 1'b0 || bus.winner !== 2'd0) begin
            errors++;
            $display("FAIL reset_status: ready=%b mv=%b ct=%b act=%b wv=%b w=%0d want 0",
                     bus.flip_ready, bus.move_pulse, bus.catch_pulse, bus.game_active,
                     bus.winner_valid, bus.winner);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dbg_state !== IDLE || bus.flip_ready !== 1'b0) begin
            errors++; $display("FAIL reset_idle: state=%0d ready=%b want IDLE/0", bus.dbg_state, bus.flip_ready);
        end
        model_clear();
    endtask

    task automatic test_invalid_n();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.n_players = (k == 0) ? 4'd5 : (k == 1) ? 4'd1 : 4'd0;
            repeat (3) @(negedge clk);
            checks++;
            if (bus.game_active !== 1'b0 || bus.dbg_state !== IDLE || bus.flip_ready !== 1'b0) begin
                errors++;
                $display("FAIL invalid_n=%0d: active=%b state=%0d ready=%b want 0/IDLE/0",
                         bus.n_players, bus.game_active, bus.dbg_state, bus.flip_ready);
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_start();
        do_reset();
        start_game(3, 1'b1);
        checks++;
        if (bus.pos_flat !== {5'd0, 5'd16, 5'd8, 5'd0} || bus.tails_flat !== {3'd0, 3'd1, 3'd1, 3'd1}) begin
            errors++; $display("FAIL start_n3_const: pos=%h tails=%h", bus.pos_flat, bus.tails_flat);
        end
    endtask

    task automatic test_drop();
        do_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.n_players = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flip_valid = 1'b1; bus.flip_match = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
        model_start(2);
        @(negedge clk);
        checks++;
        if (bus.pos_flat !== exp_pos_flat() || bus.move_pulse !== 1'b0 || bus.flip_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop: pos=%h mv=%b ready=%b want pos=%h mv=0 ready=1",
                     bus.pos_flat, bus.move_pulse, bus.flip_ready, exp_pos_flat());
        end
    endtask

    task automatic test_moves();
        do_reset();
        start_game(2, 1'b0);
        repeat (3) do_flip(1'b1);
        checks++;
        if (bus.pos_flat[4:0] !== 5'd3 || bus.cur_player !== 2'd0) begin
            errors++; $display("FAIL three_moves: pos0=%0d cur=%0d want 3/0", bus.pos_flat[4:0], bus.cur_player);
        end
        do_flip(1'b0);
        checks++;
        if (bus.cur_player !== 2'd1) begin
            errors++; $display("FAIL mismatch_next: cur=%0d want 1", bus.cur_player);
        end
        // start mid-game is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.n_players = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pos_flat !== exp_pos_flat() || bus.tails_flat !== exp_tails_flat() || bus.flip_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: pos=%h tails=%h ready=%b want %h/%h/1",
                     bus.pos_flat, bus.tails_flat, bus.flip_ready, exp_pos_flat(), exp_tails_flat());
        end
        do_reset();
        start_game(3, 1'b0);
        repeat (3) do_flip(1'b0);
        checks++;
        if (bus.cur_player !== 2'd0) begin
            errors++; $display("FAIL next_wrap_n3: cur=%0d want 0", bus.cur_player);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        start_game(4, 1'b0);
        repeat (3) do_flip(1'b0);
        repeat (5) do_flip(1'b1);
        checks++;
        if (bus.pos_flat[19:15] !== 5'd23) begin
            errors++; $display("FAIL pos_23: pos3=%0d want 23", bus.pos_flat[19:15]);
        end
        do_flip(1'b1);
        checks++;
        if (bus.pos_flat[19:15] !== 5'd0 || bus.tails_flat !== {3'd2, 3'd1, 3'd1, 3'd0}) begin
            errors++;
            $display("FAIL wrap_catch: pos3=%0d tails=%h want 0/%h", bus.pos_flat[19:15],
                     bus.tails_flat, {3'd2, 3'd1, 3'd1, 3'd0});
        end
    endtask

    task automatic test_catch_win();
        do_reset();
        start_game(2, 1'b0);
        repeat (12) do_flip(1'b1);
        checks++;
        if (bus.winner_valid !== 1'b1 || bus.winner !== 2'd0 || bus.tails_flat !== 12'd2 ||
            bus.pos_flat !== 20'd396) begin
            errors++;
            $display("FAIL catch_win: wv=%b w=%0d tails=%h pos=%h want 1/0/002/0018c",
                     bus.winner_valid, bus.winner, bus.tails_flat, bus.pos_flat);
        end
        // WIN holds and ignores flips
        bus.flip_valid = 1'b1; bus.flip_match = 1'b1;
        repeat (3) @(negedge clk);
        bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
        checks++;
        if (bus.winner_valid !== 1'b1 || bus.pos_flat !== 20'd396 || bus.flip_ready !== 1'b0) begin
            errors++;
            $display("FAIL win_hold: wv=%b pos=%h ready=%b want 1/0018c/0", bus.winner_valid, bus.pos_flat, bus.flip_ready);
        end
        start_game(3, 1'b0);
        checks++;
        if (bus.winner_valid !== 1'b0) begin
            errors++; $display("FAIL restart_wv: got %b want 0", bus.winner_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        start_game(3, 1'b0);
        do_flip(1'b1);
        do_flip(1'b0);
        do_flip(1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pos_flat !== 20'd0 || bus.tails_flat !== 12'd0 || bus.cur_player !== 2'd0 ||
            bus.flip_ready !== 1'b0 || bus.game_active !== 1'b0 || bus.winner_valid !== 1'b0 ||
            bus.move_pulse !== 1'b0 || bus.catch_pulse !== 1'b0 || bus.winner !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: pos=%h tails=%h cur=%0d ready=%b act=%b want all 0",
                     bus.pos_flat, bus.tails_flat, bus.cur_player, bus.flip_ready, bus.game_active);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_random();
        for (int g = 0; g < 6; g++) begin
            int n;
            n = $urandom_range(2, 4);
            do_reset();
            start_game(n, 1'b0);
            for (int f = 0; f < 80 && !m_won; f++) begin
                do_flip($urandom_range(0, 99) < 75);
            end
            if (m_won) begin
                @(negedge clk);
                checks++;
                if (bus.winner_valid !== 1'b1 || bus.winner !== 2'(m_cur)) begin
                    errors++;
                    $display("FAIL rand_win_hold g=%0d: wv=%b w=%0d want 1/%0d", g, bus.winner_valid, bus.winner, m_cur);
                end
            end
        end
    endtask

`ifdef CHICKEN_TURN_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        start_game(2, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.cur_player !== 2'd0) begin
            errors++; $display("FAIL timeout_early: cur=%0d want 0", bus.cur_player);
        end
        @(negedge clk);
        m_cur = 1;
        checks++;
        if (bus.cur_player !== 2'd1 || bus.flip_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_next: cur=%0d ready=%b want 1/1", bus.cur_player, bus.flip_ready);
        end
        repeat (8) @(negedge clk);
        do_flip_now(1'b1);
        checks++;
        if (bus.pos_flat[9:5] !== 5'd13 || bus.cur_player !== 2'd1) begin
            errors++; $display("FAIL timeout_flip_priority: pos1=%0d cur=%0d want 13/1", bus.pos_flat[9:5], bus.cur_player);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_invalid_n();
        test_start();
        test_drop();
        test_moves();
        test_wrap();
        test_catch_win();
        test_mid_reset();
        test_random();
`ifdef CHICKEN_TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chicken_turn_ctrl.md
# chicken_turn_ctrl

Turn scheduler for the Chicken Cha-Cha-Cha board. It owns the shared 24-tile ring and the per-player position counters for 2–4 players. It loads the start positions, grants the flip/move resource to one player at a time, and advances the active player on a matching flip. It also transfers tails when a player lands on another player's tile, and declares the winner. It sits between the card-flip input logic and the display/score logic.

## Interface
- `TILES`, 24, ring length; positions are 0..TILES-1.
- `TIMEOUT_CYC`, 1000, cycles a turn may wait for a flip (used only with `TURN_TIMEOUT_EN`).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: start/restart a game; level sampled per cycle.
- `n_players` in 4: player count; only 2, 3 or 4 are valid.
- `flip_valid` in 1: a flip result is presented.
- `flip_match` in 1: the flip matched the next tile; qualified by `flip_valid`.
- `flip_ready` out 1: the controller accepts a flip this cycle.
- `cur_player` out 2: index of the active player.
- `pos_flat` out 20: 4×5-bit positions; player i is at bits [5i+4:5i].
- `tails_flat` out 12: 4×3-bit tail counts; player i is at bits [3i+2:3i].
- `move_pulse` out 1: one-cycle pulse when the active player advances.
- `catch_pulse` out 1: one-cycle pulse when a tail is transferred.
- `game_active` out 1: high from INIT through CHECK/NEXT; low in IDLE and WIN.
- `winner_valid` out 1: high in WIN.
- `winner` out 2: winning player index; valid only while `winner_valid` is high.

## Operation
- FSM states: IDLE, INIT, WAIT_FLIP, MOVE, CHECK, NEXT, WIN.
- IDLE → INIT when `start` is high and `n_players` ∈ {2,3,4}. `start` with an invalid N is ignored; the FSM stays in IDLE.
- INIT (1 cycle):
  - Latch N.
  - Load start positions: N=2 → 0,12; N=3 → 0,8,16; N=4 → 0,6,12,18.
  - Unused player slots: position 0, tails 0.
  - Tails = 1 for each active player.
  - `cur_player` = 0.
  - Go to WAIT_FLIP.
- WAIT_FLIP: `flip_ready` = 1. On `flip_valid`:
  - match → MOVE.
  - mismatch → NEXT.
- MOVE (1 cycle):
  - pos[cur] ← pos[cur]+1; 23 wraps to 0.
  - `move_pulse` = 1.
  - Go to CHECK.
- CHECK (1 cycle):
  - Search the other active players in ascending index for pos == pos[cur].
  - On the first hit with tails > 0: victim tails −1, cur tails +1, `catch_pulse` = 1. At most one transfer per move.
  - If cur tails (after any transfer) == N → WIN, with `winner` = cur.
  - Otherwise → WAIT_FLIP; the same player continues.
- NEXT (1 cycle): `cur_player` ← (cur+1) mod N, then → WAIT_FLIP.
- WIN: all outputs hold. `start` with a valid N → INIT (restart). Otherwise the FSM stays in WIN.
- `start` in any state other than IDLE or WIN is ignored.
- Changes to `n_players` after INIT have no effect until the next INIT.
- Tail arithmetic is 3-bit unsigned. The sum of tails always equals N; a tail count never goes below 0 or above N.

## Timing
- Reset values: state IDLE, `cur_player` 0, all positions 0, all tails 0, `flip_ready` 0, `move_pulse` 0, `catch_pulse` 0, `game_active` 0, `winner_valid` 0, `winner` 0.
- `rst` asserted mid-game returns every output to its reset value immediately, with no need for a clock edge.
- All outputs are registered.
- Matching flip accepted at edge k:
  - New position and `move_pulse` are visible after edge k+1.
  - Tail update and `catch_pulse` are visible after edge k+2.
  - `flip_ready` is high again after edge k+3, or `winner_valid` is high instead.
- Mismatching flip accepted at edge k: the new `cur_player` and `flip_ready` are both visible after edge k+2.
- `flip_valid` outside WAIT_FLIP is dropped; the controller does not queue it.
- `start` held high in IDLE launches only one INIT; the game then proceeds normally.

## Configuration
- `CHICKEN_TURN_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT_FLIP and increments each cycle in WAIT_FLIP.
  - When the counter reaches `TIMEOUT_CYC`−1 with no flip, the FSM goes to NEXT, as if a mismatch had been flipped.
  - A flip arriving in that same cycle takes priority over the timeout.
- Undefined: the counter and the timeout logic are absent, and WAIT_FLIP waits indefinitely.

## Structure
- Package `chicken_pkg` holds:
  - `TILES`.
  - The start-position constants per N.
  - The FSM state enum.
  - The widths for position (5), tails (3) and player index (2).
- Sub-module `player_pos_ctr`: 5-bit mod-`TILES` counter with synchronous load (start position) and increment enable; instantiated 4 times.
- Tail bookkeeping and catch detection stay in the top level.

## Test plan
- Reset then `start` with N=3 → positions 0,8,16,0; tails 1,1,1,0; `cur_player` 0; `flip_ready` high 2 cycles after `start`.
- N=2, player 0 flips match ×3 → pos0 = 3, `cur_player` stays 0; then a mismatch → `cur_player` = 1; with N=3, a mismatch from player 2 → `cur_player` wraps to 0.
- Player at 23 flips a match → position 0 and `move_pulse` for one cycle.
- N=2, player 0 at 11 flips a match onto player 1 at 12 → `catch_pulse`; tails 2,0; `winner_valid` = 1 with `winner` = 0 on the next cycle.
- `start` with N=5 → stays in IDLE, `game_active` 0. Then `rst` pulsed mid-game → all outputs return to reset values asynchronously.
- With `CHICKEN_TURN_TIMEOUT_EN` and `TIMEOUT_CYC`=10: no flip for 10 cycles → `cur_player` advances. A flip arriving on cycle 10 is processed instead of the timeout.
